// File: rtl/bkm_csd_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module   : bkm_csd_stream_driver
//  Purpose  : Operand driver for the BKM datapath. It buffers N_CH packed
//             W-bit two's-complement operands per transaction in a DEPTH-entry
//             FIFO. It converts the FIFO head to W signed digits per channel,
//             either canonical CSD (non-adjacent form) or plain two's-complement
//             digits, selected per transaction. The converted transaction is
//             presented on a registered valid/ready output stream.
//
//  Ports    : clk          rising-edge clock
//             srst         synchronous active-high reset
//             enable       global advance enable; 0 freezes all state
//             in_valid     input transaction valid
//             in_ready     FIFO can accept a transaction this cycle
//             in_mode_csd  1 = CSD digits, 0 = two's-complement digits
//             in_data      channel c at [c*W +: W]
//             out_valid    converted transaction valid
//             out_ready    downstream accepts
//             out_csd      channel c at [c*2W +: 2W]; digit i at [2i+1:2i]
//                          (00 = 0, 01 = +1, 11 = -1)
//             level        FIFO occupancy (output register not included)
//             tx_count     completed output transfers, wraps modulo 2^CW
//
//  Revision : 1.0  initial pipelined release
// ============================================================================
module bkm_csd_stream_driver #(
    parameter int W     = 64,
    parameter int N_CH  = 4,
    parameter int DEPTH = 4,
    parameter int CW    = 32
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode_csd,
    input  logic [N_CH*W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N_CH*2*W-1:0]        out_csd,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CW-1:0]              tx_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH+1);
    localparam int c_EW = N_CH*W + 1;           // {mode, data}
    localparam int c_OW = N_CH*2*W;

    localparam logic [c_LW-1:0] c_FULL    = c_LW'(DEPTH);
    localparam logic [c_LW-1:0] c_LVL_ONE = c_LW'(1);
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [CW-1:0]   c_CNT_ONE = CW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic            r_out_valid;
    logic [c_OW-1:0] r_out_csd;
    logic [CW-1:0]   r_tx_count;

    // ------------------------------------------------------------------
    // Handshake qualifiers. in_ready looks only at registered occupancy,
    // so a full FIFO refuses input even on a cycle where it pops.
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_push;
    logic w_load;
    logic w_xfer;

    assign w_in_ready = enable & (r_level != c_FULL);
    assign w_push     = in_valid & w_in_ready;
    assign w_load     = enable & (r_level != '0) & (~r_out_valid | out_ready);
    assign w_xfer     = enable & r_out_valid & out_ready;

    // ------------------------------------------------------------------
    // FIFO head and digit conversion
    // ------------------------------------------------------------------
    logic [c_EW-1:0]   w_head;
    logic              w_head_mode;
    logic [N_CH*W-1:0] w_head_data;
    logic [c_OW-1:0]   w_conv;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_mode = w_head[c_EW-1];
    assign w_head_data = w_head[N_CH*W-1:0];

    // CSD uses the carry recoding d_i = x_i + c_i - 2*c_{i+1}, with
    // c_{i+1} = majority(x_i, x_{i+1}, c_i) over the sign-extended operand.
    // A digit is non-zero exactly when x_i ^ c_i; its sign then equals
    // x_{i+1}. Sign extension makes the final carry equal the sign bit, so
    // W digits always represent the signed value exactly.
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [W:0]   w_xe;
            logic [W-1:0] w_carry;

            assign w_xe       = {w_head_data[c*W+W-1], w_head_data[c*W +: W]};
            assign w_carry[0] = 1'b0;

            for (genvar i = 0; i < W; i++) begin : g_dig
                logic w_nz;
                logic w_tc_neg;

                if (i < W-1) begin : g_carry
                    assign w_carry[i+1] = (w_xe[i] & w_xe[i+1]) |
                                          (w_xe[i] & w_carry[i]) |
                                          (w_xe[i+1] & w_carry[i]);
                end

                assign w_nz = w_xe[i] ^ w_carry[i];
                // Only the operand MSB carries negative weight.
                assign w_tc_neg = (i == W-1) ? w_xe[i] : 1'b0;

                assign w_conv[c*2*W + 2*i +: 2] = w_head_mode ?
                                                  {w_nz & w_xe[i+1], w_nz} :
                                                  {w_tc_neg, w_xe[i]};
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: pointers define validity)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_mode_csd, in_data};
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, output register and transfer counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_csd   <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end

            case ({w_push, w_load})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase

            // A load refills the register in the same edge it is drained.
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_csd   <= w_conv;
            end else if (w_xfer) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer) begin
                r_tx_count <= r_tx_count + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_csd   = r_out_csd;
    assign level     = r_level;
    assign tx_count  = r_tx_count;

endmodule
`default_nettype wire

// File: tb/tb_bkm_csd_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bkm_csd_stream_driver
//  Purpose  : Directed-vector bench for bkm_csd_stream_driver (W=8, N_CH=2,
//             DEPTH=4, CW=4) followed by a random valid/ready stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bkm_csd_stream_driver;

    localparam int W     = 8;
    localparam int N_CH  = 2;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int NTX   = 3000;

    logic                 clk = 1'b0;
    logic                 srst;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_mode_csd;
    logic [N_CH*W-1:0]    in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_CH*2*W-1:0]  out_csd;
    logic [2:0]           level;
    logic [CW-1:0]        tx_count;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [CW-1:0] exp_tx;

    // Values 1..5, two's-complement digits, channel 0
    logic [15:0] fexp [5] = '{16'h0001, 16'h0004, 16'h0005, 16'h0010, 16'h0011};
    // CSD of 07, FF, 7F, 80
    logic [7:0]  sval [4] = '{8'h07, 8'hFF, 8'h7F, 8'h80};
    logic [15:0] sexp [4] = '{16'h0043, 16'h0003, 16'h4003, 16'hC000};

    always #5 clk = ~clk;

    bkm_csd_stream_driver #(
        .W     (W),
        .N_CH  (N_CH),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode_csd (in_mode_csd),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_csd     (out_csd),
        .level       (level),
        .tx_count    (tx_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint decode(input logic [2*W-1:0] d);
        longint v = 0;
        for (int i = 0; i < W; i++) begin
            if (d[2*i +: 2] == 2'b01) v += longint'(1) << i;
            if (d[2*i +: 2] == 2'b11) v -= longint'(1) << i;
        end
        return v;
    endfunction

    // Count of illegal 10 digits plus adjacent non-zero digit pairs
    function automatic int naf_violations(input logic [2*W-1:0] d);
        int n = 0;
        for (int i = 0; i < W; i++) begin
            if (d[2*i +: 2] == 2'b10) n++;
            if (i < W-1 && d[2*i] && d[2*i+2]) n++;
        end
        return n;
    endfunction

    function automatic logic [2*W-1:0] twos_digits(input logic [W-1:0] x);
        logic [2*W-1:0] r = '0;
        for (int i = 0; i < W; i++) begin
            if (x[i]) r[2*i +: 2] = (i == W-1) ? 2'b11 : 2'b01;
        end
        return r;
    endfunction

    task automatic single(input string tag, input logic m, input logic [N_CH*W-1:0] d,
                          input logic [N_CH*2*W-1:0] e);
        in_valid = 1'b1; in_mode_csd = m; in_data = d;
        step();                                   // edge k: accept
        in_valid = 1'b0;
        check({tag, "_lat0"}, 64'(out_valid), 64'(0));
        check({tag, "_lvl1"}, 64'(level), 64'(1));
        step();                                   // edge k+1: load
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_csd"}, 64'(out_csd), 64'(e));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_tx = exp_tx + 1'b1;
        check({tag, "_tx"}, 64'(tx_count), 64'(exp_tx));
        check({tag, "_done"}, 64'(out_valid), 64'(0));
    endtask

    task automatic push(input logic m, input logic [N_CH*W-1:0] d);
        in_valid = 1'b1; in_mode_csd = m; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int got;
        logic [16:0] q[$];
        logic [16:0] ent;
        logic signed [W-1:0] sx;

        srst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_mode_csd = 1'b0;
        in_data = '0; out_ready = 1'b0; exp_tx = '0;
        step(); step();
        srst = 1'b0;
        #1;
        check("rst_level", 64'(level), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_csd", 64'(out_csd), 64'(0));
        check("rst_tx", 64'(tx_count), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));

        // Directed conversions
        single("csd07", 1'b1, {8'h80, 8'h07}, {16'hC000, 16'h0043});
        single("tc07",  1'b0, {8'hFF, 8'h07}, {16'hD555, 16'h0015});
        single("csdFF", 1'b1, {8'h7F, 8'hFF}, {16'h4003, 16'h0003});
        single("tc80",  1'b0, {8'h00, 8'h80}, {16'h0000, 16'hC000});

        // Fill under backpressure: 1 in output register + 4 in FIFO
        for (int i = 0; i < 5; i++) push(1'b0, {8'h00, 8'(i + 1)});
        #1;
        check("fill_level", 64'(level), 64'(4));
        check("fill_ready", 64'(in_ready), 64'(0));
        check("fill_valid", 64'(out_valid), 64'(1));
        check("fill_head", 64'(out_csd), 64'(fexp[0]));
        push(1'b0, {8'h00, 8'h09});                // refused while full
        check("full_level", 64'(level), 64'(4));
        check("full_hold", 64'(out_csd), 64'(fexp[0]));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 64'(out_valid), 64'(1));
            check("drain_csd", 64'(out_csd), 64'(fexp[i]));
            step();
        end
        out_ready = 1'b0;
        exp_tx = exp_tx + 4'd5;
        check("drain_empty", 64'(out_valid), 64'(0));
        check("drain_level", 64'(level), 64'(0));
        check("drain_tx", 64'(tx_count), 64'(exp_tx));

        // Simultaneous push and pop at level 2
        for (int i = 0; i < 3; i++) push(1'b1, {8'h00, sval[i]});
        check("pp_pre_level", 64'(level), 64'(2));
        check("pp_pre_csd", 64'(out_csd), 64'(sexp[0]));
        in_valid = 1'b1; in_mode_csd = 1'b1; in_data = {8'h00, sval[3]}; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pp_level", 64'(level), 64'(2));
        for (int i = 1; i < 4; i++) begin
            check("pp_csd", 64'(out_csd), 64'(sexp[i]));
            step();
        end
        out_ready = 1'b0;
        exp_tx = exp_tx + 4'd4;
        check("pp_empty", 64'(out_valid), 64'(0));
        check("pp_tx", 64'(tx_count), 64'(exp_tx));

        // Reset mid-operation
        for (int i = 0; i < 4; i++) push(1'b0, {8'h00, 8'(8'h11 + i)});
        check("mr_level", 64'(level), 64'(3));
        check("mr_valid", 64'(out_valid), 64'(1));
        srst = 1'b1;
        step();
        srst = 1'b0;
        exp_tx = '0;
        check("mr_rst_level", 64'(level), 64'(0));
        check("mr_rst_valid", 64'(out_valid), 64'(0));
        check("mr_rst_csd", 64'(out_csd), 64'(0));
        check("mr_rst_tx", 64'(tx_count), 64'(0));
        step(); step();
        check("mr_no_stale", 64'(out_valid), 64'(0));
        single("post_rst", 1'b1, {8'h00, 8'h55}, {16'h0000, 16'h1111});

        // enable=0 freezes everything
        for (int i = 0; i < 3; i++) push(1'b0, {8'h00, 8'(i + 1)});
        enable = 1'b0; in_valid = 1'b1; in_data = {8'h00, 8'h05}; out_ready = 1'b1;
        #1;
        check("en_ready", 64'(in_ready), 64'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_level", 64'(level), 64'(2));
            check("en_valid", 64'(out_valid), 64'(1));
            check("en_csd", 64'(out_csd), 64'(fexp[0]));
            check("en_tx", 64'(tx_count), 64'(exp_tx));
        end
        enable = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("en_drain", 64'(out_csd), 64'(fexp[i]));
            step();
        end
        out_ready = 1'b0;
        exp_tx = exp_tx + 4'd3;
        check("en_tx_after", 64'(tx_count), 64'(exp_tx));

        // 17 transfers with a 4-bit counter wrap to 1
        srst = 1'b1; step(); srst = 1'b0;
        sent = 0; got = 0; out_ready = 1'b1; in_mode_csd = 1'b0;
        for (int n = 0; n < 200 && got < 17; n++) begin
            in_valid = (sent < 17);
            in_data  = {8'h00, 8'(sent)};
            #1;
            if (out_valid) begin
                check("wrap_order", 64'(decode(out_csd[15:0])), 64'(got));
                got++;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("wrap_cnt", 64'(got), 64'(17));
        check("wrap_tx", 64'(tx_count), 64'(1));
        exp_tx = 4'd1;

        // Random valid/ready stream with a scoreboard
        sent = 0; got = 0;
        for (int n = 0; n < 40000 && got < NTX; n++) begin
            in_valid    = (sent < NTX) && ($urandom_range(0, 3) != 0);
            in_mode_csd = 1'($urandom_range(0, 1));
            in_data     = 16'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_underflow", 64'(0), 64'(1));
                end else begin
                    ent = q.pop_front();
                    for (int c = 0; c < N_CH; c++) begin
                        sx = ent[c*W +: W];
                        check("rnd_val", 64'(decode(out_csd[c*2*W +: 2*W])), 64'(longint'(sx)));
                        if (ent[16])
                            check("rnd_naf", 64'(naf_violations(out_csd[c*2*W +: 2*W])), 64'(0));
                        else
                            check("rnd_2c", 64'(out_csd[c*2*W +: 2*W]), 64'(twos_digits(ent[c*W +: W])));
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_mode_csd, in_data});
                sent++;
            end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        exp_tx = exp_tx + CW'(NTX);
        check("rnd_count", 64'(got), 64'(NTX));
        check("rnd_tx", 64'(tx_count), 64'(exp_tx));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
